vga_timing_gen: RTL and testbench

//  Parametrised VGA raster timing generator; successor to the fixed 800x600 hsync-only counter.

---
 rtl/vga_timing_pkg.sv | 42 ++++
 rtl/pix_strobe_gen.sv | 30 +++
 rtl/vga_timing_gen.sv | 112 +++++++++++
 tb/tb_vga_timing_gen.sv | 241 ++++++++++++++++++++++++
 4 files changed

// File: rtl/vga_timing_pkg.sv
// Shared VGA timing presets (800x600@60, 640x480@60) and counter-width helper
// used by the raster timing generator.
package vga_timing_pkg;

  typedef struct packed {
    int h_visible;
    int h_front;
    int h_sync;
    int h_back;
    int v_visible;
    int v_front;
    int v_sync;
    int v_back;
  } vga_timing_t;

  typedef enum logic {
    MODE_800X600,
    MODE_640X480
  } vga_mode_e;

  localparam vga_timing_t SVGA_800X600 = '{
    h_visible: 800, h_front: 40, h_sync: 128, h_back: 88,
    v_visible: 600, v_front: 1,  v_sync: 4,   v_back: 23
  };

  localparam vga_timing_t VGA_640X480 = '{
    h_visible: 640, h_front: 16, h_sync: 96, h_back: 48,
    v_visible: 480, v_front: 10, v_sync: 2,  v_back: 33
  };

  function automatic vga_timing_t mode_timing(input vga_mode_e mode);
    return (mode == MODE_640X480) ? VGA_640X480 : SVGA_800X600;
  endfunction

  // Bits needed so the counters can hold H_TOTAL-1 and V_TOTAL-1.
  function automatic int calc_cw(input int h_total, input int v_total);
    int m;
    m = (h_total > v_total) ? h_total : v_total;
    return (m <= 2) ? 1 : $clog2(m);
  endfunction

endpackage

// File: rtl/pix_strobe_gen.sv
// Pixel strobe divider: a tick counter over CLK_DIV clk cycles that emits a
// one-clk strobe on its last count while enabled.
module pix_strobe_gen #(
  parameter int CLK_DIV = 6
) (
  input  logic clk,
  input  logic nrst,
  input  logic enable,
  output logic strobe
);

  localparam int             TW   = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam logic [TW-1:0]  LAST = TW'(CLK_DIV - 1);

  logic [TW-1:0] tick;

  // Dropping enable clears the phase so a restart always waits a full period.
  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      tick <= '0;
    end else if (!enable || tick == LAST) begin
      tick <= '0;
    end else begin
      tick <= tick + TW'(1);
    end
  end

  assign strobe = enable && (tick == LAST);

endmodule

// File: rtl/vga_timing_gen.sv
// Parametrised VGA raster timing generator: pixel strobe, H/V counters and a
// registered decode of sync, visible area, coordinates and start pulses.
module vga_timing_gen
  import vga_timing_pkg::*;
#(
  parameter int CLK_DIV   = 6,
  parameter int H_VISIBLE = SVGA_800X600.h_visible,
  parameter int H_FRONT   = SVGA_800X600.h_front,
  parameter int H_SYNC    = SVGA_800X600.h_sync,
  parameter int H_BACK    = SVGA_800X600.h_back,
  parameter int V_VISIBLE = SVGA_800X600.v_visible,
  parameter int V_FRONT   = SVGA_800X600.v_front,
  parameter int V_SYNC    = SVGA_800X600.v_sync,
  parameter int V_BACK    = SVGA_800X600.v_back,
  parameter bit HSYNC_POL = 1'b1,
  parameter bit VSYNC_POL = 1'b1,
  parameter int CW        = calc_cw(H_VISIBLE + H_FRONT + H_SYNC + H_BACK,
                                    V_VISIBLE + V_FRONT + V_SYNC + V_BACK)
) (
  input  logic          clk,
  input  logic          nrst,
  input  logic          enable,
  output logic          pix_en,
  output logic          hsync,
  output logic          vsync,
  output logic          visible,
  output logic [CW-1:0] x,
  output logic [CW-1:0] y,
  output logic          line_start,
  output logic          frame_start
);

  localparam int H_TOTAL = H_VISIBLE + H_FRONT + H_SYNC + H_BACK;
  localparam int V_TOTAL = V_VISIBLE + V_FRONT + V_SYNC + V_BACK;

  localparam logic [CW-1:0] H_LAST    = CW'(H_TOTAL - 1);
  localparam logic [CW-1:0] V_LAST    = CW'(V_TOTAL - 1);
  localparam logic [CW-1:0] H_VIS_END = CW'(H_VISIBLE);
  localparam logic [CW-1:0] V_VIS_END = CW'(V_VISIBLE);
  localparam logic [CW-1:0] HS_START  = CW'(H_VISIBLE + H_FRONT);
  localparam logic [CW-1:0] HS_END    = CW'(H_VISIBLE + H_FRONT + H_SYNC);
  localparam logic [CW-1:0] VS_START  = CW'(V_VISIBLE + V_FRONT);
  localparam logic [CW-1:0] VS_END    = CW'(V_VISIBLE + V_FRONT + V_SYNC);

  logic          strobe;
  logic [CW-1:0] hcnt;
  logic [CW-1:0] vcnt;
  logic          vis_d;
  logic          hs_d;
  logic          vs_d;

  pix_strobe_gen #(
    .CLK_DIV(CLK_DIV)
  ) u_strobe (
    .clk    (clk),
    .nrst   (nrst),
    .enable (enable),
    .strobe (strobe)
  );

  // Decode of the position about to be presented; registered on the strobe.
  always_comb begin
    vis_d = (hcnt < H_VIS_END) && (vcnt < V_VIS_END);
    hs_d  = ((hcnt >= HS_START) && (hcnt < HS_END)) ? HSYNC_POL : ~HSYNC_POL;
    vs_d  = ((vcnt >= VS_START) && (vcnt < VS_END)) ? VSYNC_POL : ~VSYNC_POL;
  end

  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      hcnt        <= '0;
      vcnt        <= '0;
      pix_en      <= 1'b0;
      x           <= '0;
      y           <= '0;
      visible     <= 1'b0;
      line_start  <= 1'b0;
      frame_start <= 1'b0;
      hsync       <= ~HSYNC_POL;
      vsync       <= ~VSYNC_POL;
    end else if (!enable) begin
      hcnt        <= '0;
      vcnt        <= '0;
      pix_en      <= 1'b0;
      x           <= '0;
      y           <= '0;
      visible     <= 1'b0;
      line_start  <= 1'b0;
      frame_start <= 1'b0;
      hsync       <= ~HSYNC_POL;
      vsync       <= ~VSYNC_POL;
    end else begin
      pix_en <= strobe;
      if (strobe) begin
        x           <= hcnt;
        y           <= vcnt;
        visible     <= vis_d;
        hsync       <= hs_d;
        vsync       <= vs_d;
        line_start  <= (hcnt == '0);
        frame_start <= (hcnt == '0) && (vcnt == '0);
        // hcnt/vcnt always point at the next position to present.
        if (hcnt == H_LAST) begin
          hcnt <= '0;
          vcnt <= (vcnt == V_LAST) ? '0 : vcnt + CW'(1);
        end else begin
          hcnt <= hcnt + CW'(1);
        end
      end
    end
  end

endmodule

// File: tb/tb_vga_timing_gen.sv
// Directed bench for vga_timing_gen: default 800x600 timing, a tiny raster with
// inverted sync polarity, and a narrow-line raster with the default vertical timing.
module tb_vga_timing_gen;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic nrst;
  logic en_a, en_b, en_c;

  logic        pe_a, hs_a, vs_a, vis_a, ls_a, fs_a;
  logic [10:0] x_a, y_a;
  logic        pe_b, hs_b, vs_b, vis_b, ls_b, fs_b;
  logic [10:0] x_b, y_b;
  logic        pe_c, hs_c, vs_c, vis_c, ls_c, fs_c;
  logic [10:0] x_c, y_c;

  int checks = 0;
  int errors = 0;

  vga_timing_gen #(.CW(11)) dut_a (
    .clk(clk), .nrst(nrst), .enable(en_a),
    .pix_en(pe_a), .hsync(hs_a), .vsync(vs_a), .visible(vis_a),
    .x(x_a), .y(y_a), .line_start(ls_a), .frame_start(fs_a)
  );

  vga_timing_gen #(
    .CLK_DIV(1),
    .H_VISIBLE(4), .H_FRONT(1), .H_SYNC(2), .H_BACK(1),
    .V_VISIBLE(3), .V_FRONT(1), .V_SYNC(1), .V_BACK(1),
    .HSYNC_POL(1'b0), .VSYNC_POL(1'b0), .CW(11)
  ) dut_b (
    .clk(clk), .nrst(nrst), .enable(en_b),
    .pix_en(pe_b), .hsync(hs_b), .vsync(vs_b), .visible(vis_b),
    .x(x_b), .y(y_b), .line_start(ls_b), .frame_start(fs_b)
  );

  vga_timing_gen #(
    .CLK_DIV(1),
    .H_VISIBLE(4), .H_FRONT(1), .H_SYNC(2), .H_BACK(1),
    .CW(11)
  ) dut_c (
    .clk(clk), .nrst(nrst), .enable(en_c),
    .pix_en(pe_c), .hsync(hs_c), .vsync(vs_c), .visible(vis_c),
    .x(x_c), .y(y_c), .line_start(ls_c), .frame_start(fs_c)
  );

  task automatic check_output(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("[TB] FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  // Waits for the next pix_en of dut_a; returns the clk count or -1 on timeout.
  task automatic wait_pix_a(output int clks);
    clks = -1;
    for (int i = 1; i <= 12; i++) begin
      @(posedge clk);
      @(negedge clk);
      if (pe_a) begin
        clks = i;
        break;
      end
    end
    if (clks < 0) check_output("pix_a_timeout", {31'd0, pe_a}, 32'd1);
  endtask

  task automatic check_a_reset(input string tag);
    check_output({tag, "_pix_en"},  {31'd0, pe_a},  32'd0);
    check_output({tag, "_hsync"},   {31'd0, hs_a},  32'd0);
    check_output({tag, "_vsync"},   {31'd0, vs_a},  32'd0);
    check_output({tag, "_visible"}, {31'd0, vis_a}, 32'd0);
    check_output({tag, "_x"},       {21'd0, x_a},   32'd0);
    check_output({tag, "_y"},       {21'd0, y_a},   32'd0);
    check_output({tag, "_ls"},      {31'd0, ls_a},  32'd0);
    check_output({tag, "_fs"},      {31'd0, fs_a},  32'd0);
  endtask

  task automatic check_a_first(input string tag, input int clks);
    check_output({tag, "_latency"}, clks,           32'd6);
    check_output({tag, "_x"},       {21'd0, x_a},   32'd0);
    check_output({tag, "_y"},       {21'd0, y_a},   32'd0);
    check_output({tag, "_fs"},      {31'd0, fs_a},  32'd1);
    check_output({tag, "_ls"},      {31'd0, ls_a},  32'd1);
    check_output({tag, "_visible"}, {31'd0, vis_a}, 32'd1);
    check_output({tag, "_hsync"},   {31'd0, hs_a},  32'd0);
  endtask

  initial begin
    int n;
    int rise_x, fall_x, visfall_x, wrap_prev_x, bad_period;
    int pe_count;
    int ex, ey;
    logic prev_hs, prev_vis;
    logic [10:0] prev_x;
    int miss, fs_first, fs_second, rise_y, fall_y, midline, last_y;
    logic prev_vs;

    nrst = 1'b0;
    en_a = 1'b0;
    en_b = 1'b0;
    en_c = 1'b0;
    repeat (3) @(negedge clk);

    $display("[TB] reset state");
    check_a_reset("reset_a");
    check_output("reset_b_hsync", {31'd0, hs_b}, 32'd1);
    check_output("reset_b_vsync", {31'd0, vs_b}, 32'd1);

    $display("[TB] first pixel latency and strobe period");
    nrst = 1'b1;
    en_a = 1'b1;
    wait_pix_a(n);
    check_a_first("first", n);
    wait_pix_a(n);
    check_output("period", n, 32'd6);
    check_output("second_x", {21'd0, x_a}, 32'd1);
    check_output("second_fs", {31'd0, fs_a}, 32'd0);
    check_output("second_ls", {31'd0, ls_a}, 32'd0);

    $display("[TB] horizontal decode across line 0");
    rise_x = -1; fall_x = -1; visfall_x = -1; wrap_prev_x = -1; bad_period = 0;
    prev_hs = hs_a; prev_vis = vis_a; prev_x = x_a;
    for (int i = 0; i < 1100; i++) begin
      wait_pix_a(n);
      if (n != 6) bad_period++;
      if (!prev_hs && hs_a && rise_x < 0) rise_x = int'(x_a);
      if (prev_hs && !hs_a && fall_x < 0) fall_x = int'(x_a);
      if (prev_vis && !vis_a && visfall_x < 0) visfall_x = int'(x_a);
      if (x_a == 11'd0) begin
        wrap_prev_x = int'(prev_x);
        break;
      end
      prev_hs = hs_a; prev_vis = vis_a; prev_x = x_a;
    end
    check_output("hsync_rise_x", rise_x, 32'd840);
    check_output("hsync_fall_x", fall_x, 32'd968);
    check_output("visible_fall_x", visfall_x, 32'd800);
    check_output("wrap_prev_x", wrap_prev_x, 32'd1055);
    check_output("wrap_y", {21'd0, y_a}, 32'd1);
    check_output("wrap_ls", {31'd0, ls_a}, 32'd1);
    check_output("wrap_fs", {31'd0, fs_a}, 32'd0);
    check_output("wrap_visible", {31'd0, vis_a}, 32'd1);
    check_output("line_period_errs", bad_period, 32'd0);

    $display("[TB] enable drop mid-frame");
    for (int i = 0; i < 400; i++) begin
      if (x_a == 11'd300) break;
      wait_pix_a(n);
    end
    check_output("drop_at_x", {21'd0, x_a}, 32'd300);
    check_output("drop_at_y", {21'd0, y_a}, 32'd1);
    check_output("drop_pre_visible", {31'd0, vis_a}, 32'd1);
    en_a = 1'b0;
    @(posedge clk);
    @(negedge clk);
    check_a_reset("drop");
    pe_count = 0;
    repeat (10) begin
      @(posedge clk);
      @(negedge clk);
      if (pe_a) pe_count++;
    end
    check_output("drop_idle_pix", pe_count, 32'd0);
    en_a = 1'b1;
    wait_pix_a(n);
    check_a_first("reenable", n);

    $display("[TB] async reset during hsync");
    for (int i = 0; i < 1000; i++) begin
      if (x_a == 11'd900) break;
      wait_pix_a(n);
    end
    check_output("rst_at_x", {21'd0, x_a}, 32'd900);
    check_output("rst_pre_hsync", {31'd0, hs_a}, 32'd1);
    nrst = 1'b0;
    #1;
    check_a_reset("async_rst");
    @(negedge clk);
    nrst = 1'b1;
    wait_pix_a(n);
    check_a_first("post_rst", n);
    en_a = 1'b0;

    $display("[TB] small raster, CLK_DIV=1, negative sync");
    en_b = 1'b1;
    for (int i = 0; i < 96; i++) begin
      @(posedge clk);
      @(negedge clk);
      ex = i % 8;
      ey = (i / 8) % 6;
      check_output($sformatf("small_x_%0d", i), {21'd0, x_b}, ex);
      check_output($sformatf("small_y_%0d", i), {21'd0, y_b}, ey);
      check_output($sformatf("small_flags_%0d", i),
                   {26'd0, pe_b, hs_b, vs_b, vis_b, ls_b, fs_b},
                   {26'd0, 1'b1,
                    !(ex >= 5 && ex < 7),
                    !(ey == 4),
                    (ex < 4 && ey < 3),
                    (ex == 0),
                    (ex == 0 && ey == 0)});
    end
    en_b = 1'b0;

    $display("[TB] default vertical timing, narrow lines");
    en_c = 1'b1;
    miss = 0; fs_first = -1; fs_second = -1; rise_y = -1; fall_y = -1;
    midline = 0; last_y = -1; prev_vs = 1'b0;
    for (int i = 0; i < 5032; i++) begin
      @(posedge clk);
      @(negedge clk);
      if (!pe_c) miss++;
      if (fs_c) begin
        if (fs_first < 0) fs_first = i;
        else if (fs_second < 0) fs_second = i;
      end
      if (i > 0 && vs_c != prev_vs) begin
        if (x_c != 11'd0) midline++;
        if (vs_c && rise_y < 0) rise_y = int'(y_c);
        if (!vs_c && fall_y < 0) fall_y = int'(y_c);
      end
      if (i == 0) check_output("v_first_vsync", {31'd0, vs_c}, 32'd0);
      if (i == 5023) last_y = int'(y_c);
      prev_vs = vs_c;
    end
    check_output("v_missed_strobes", miss, 32'd0);
    check_output("v_fs_first", fs_first, 32'd0);
    check_output("v_fs_second", fs_second, 32'd5024);
    check_output("vsync_rise_y", rise_y, 32'd601);
    check_output("vsync_fall_y", fall_y, 32'd605);
    check_output("vsync_midline", midline, 32'd0);
    check_output("v_last_y", last_y, 32'd627);
    en_c = 1'b0;

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
